// File: rtl/instruction_memory_loader_pkg.sv
`default_nettype none
// ============================================================================
// Module      : instruction_memory_loader_pkg
// Description : Shared types and constants for the instruction memory loader.
//               Holds the 3-bit state encoding, the length-field width and a
//               helper for the word capacity.
// Revision    : 1.0 - initial release
// ============================================================================
package instruction_memory_loader_pkg;

  localparam int LEN_WIDTH   = 16;
  localparam int STATE_WIDTH = 3;

  typedef enum logic [STATE_WIDTH-1:0] {
    ST_IDLE   = 3'd0,
    ST_LEN_LO = 3'd1,
    ST_LEN_HI = 3'd2,
    ST_DATA   = 3'd3,
    ST_WRITE  = 3'd4,
    ST_DONE   = 3'd5,
    ST_ERROR  = 3'd6
  } state_t;

  // Number of 32-bit words that fit in a memory of the given byte size.
  function automatic int capacity_words(input int memory_size);
    return memory_size / 4;
  endfunction

endpackage
`default_nettype wire

// File: rtl/instruction_memory_loader_if.sv
`default_nettype none
// ============================================================================
// Module      : instruction_memory_loader_if
// Description : Byte-stream input and instruction-memory write port of the
//               loader. master = loader side, slave = host/memory side.
// Revision    : 1.0 - initial release
// ============================================================================
interface instruction_memory_loader_if;

  logic [7:0]  byte_in;
  logic        byte_valid;
  logic        byte_ready;
  logic        mem_we;
  logic [31:0] mem_addr;
  logic [31:0] mem_wdata;

  modport master (
    input  byte_in, byte_valid,
    output byte_ready, mem_we, mem_addr, mem_wdata
  );

  modport slave (
    output byte_in, byte_valid,
    input  byte_ready, mem_we, mem_addr, mem_wdata
  );

endinterface
`default_nettype wire

// File: rtl/instruction_memory_loader_word_assembler.sv
`default_nettype none
// ============================================================================
// Module      : instruction_memory_loader_word_assembler
// Description : Collects four stream bytes into a little-endian 32-bit word.
//               Lanes 0..2 are registered; the fourth byte is merged straight
//               from the input so the complete word is available on the same
//               edge that accepts the last byte (word_full).
// Revision    : 1.0 - initial release
// ============================================================================
module instruction_memory_loader_word_assembler (
  input  wire logic        clk,
  input  wire logic        reset,
  input  wire logic        clear,
  input  wire logic        shift_en,
  input  wire logic [7:0]  byte_in,
  output logic      [31:0] word,
  output logic             word_full
);

  logic [1:0]  byte_cnt;
  logic [23:0] lanes;

  // Store each accepted byte in the lane selected by the byte counter.
  always_ff @(posedge clk) begin
    if (!reset) begin
      byte_cnt <= 2'd0;
      lanes    <= 24'd0;
    end else if (clear) begin
      byte_cnt <= 2'd0;
      lanes    <= 24'd0;
    end else if (shift_en) begin
      case (byte_cnt)
        2'd0:    lanes[7:0]   <= byte_in;
        2'd1:    lanes[15:8]  <= byte_in;
        2'd2:    lanes[23:16] <= byte_in;
        default: lanes        <= lanes;
      endcase
      byte_cnt <= byte_cnt + 2'd1;
    end
  end

  // The fourth byte completes the word; the counter wraps back to lane 0.
  always_comb begin
    word      = {byte_in, lanes};
    word_full = shift_en && (byte_cnt == 2'd3);
  end

endmodule
`default_nettype wire

// File: rtl/instruction_memory_loader.sv
`default_nettype none
// ============================================================================
// Module      : instruction_memory_loader
// Description : Receives a program image (16-bit word count, then words LSB
//               first) over a byte stream and writes it into instruction
//               memory. Keeps the core held in reset until loading completes;
//               oversize images end in ERROR with the core still held.
// Revision    : 1.0 - initial release
// ============================================================================
module instruction_memory_loader
  import instruction_memory_loader_pkg::*;
#(
  parameter int          MEMORY_SIZE  = 1024,
  parameter logic [31:0] BASE_ADDRESS = 32'h0000_0000
) (
  input  wire logic                   clk,
  input  wire logic                   reset,
  input  wire logic                   start,
  instruction_memory_loader_if.master bus,
  output logic                        cpu_hold,
  output logic                        done,
  output logic                        error
);

  localparam logic [LEN_WIDTH:0] CAPACITY = (LEN_WIDTH+1)'(capacity_words(MEMORY_SIZE));

  state_t               state;
  logic [7:0]           len_lo;
  logic [LEN_WIDTH-1:0] words_left;

  logic                 start_ok;
  logic                 transfer;
  logic                 shift_en;
  logic [LEN_WIDTH-1:0] len;
  logic [31:0]          asm_word;
  logic                 word_full;

  // Handshake decode; start is only honoured in the resting states.
  always_comb begin
    start_ok = start && ((state == ST_IDLE) || (state == ST_DONE) || (state == ST_ERROR));
    transfer = bus.byte_valid && bus.byte_ready;
    shift_en = transfer && (state == ST_DATA);
    len      = {bus.byte_in, len_lo};
  end

  instruction_memory_loader_word_assembler u_word_assembler (
    .clk       (clk),
    .reset     (reset),
    .clear     (start_ok),
    .shift_en  (shift_en),
    .byte_in   (bus.byte_in),
    .word      (asm_word),
    .word_full (word_full)
  );

  // Load sequencer with registered handshake, memory-port and status outputs.
  always_ff @(posedge clk) begin
    if (!reset) begin
      state          <= ST_IDLE;
      bus.byte_ready <= 1'b0;
      bus.mem_we     <= 1'b0;
      bus.mem_addr   <= BASE_ADDRESS;
      bus.mem_wdata  <= 32'd0;
      done           <= 1'b0;
      error          <= 1'b0;
      cpu_hold       <= 1'b1;
      len_lo         <= 8'd0;
      words_left     <= '0;
    end else begin
      bus.mem_we <= 1'b0;
      case (state)
        ST_IDLE, ST_DONE, ST_ERROR: begin
          if (start_ok) begin
            state          <= ST_LEN_LO;
            bus.byte_ready <= 1'b1;
            bus.mem_addr   <= BASE_ADDRESS;
            done           <= 1'b0;
            error          <= 1'b0;
            cpu_hold       <= 1'b1;
          end
        end
        ST_LEN_LO: begin
          if (transfer) begin
            len_lo <= bus.byte_in;
            state  <= ST_LEN_HI;
          end
        end
        ST_LEN_HI: begin
          if (transfer) begin
            words_left <= len;
            if (len == '0) begin
              state          <= ST_DONE;
              bus.byte_ready <= 1'b0;
              done           <= 1'b1;
              cpu_hold       <= 1'b0;
            end else if ({1'b0, len} > CAPACITY) begin
              state          <= ST_ERROR;
              bus.byte_ready <= 1'b0;
              error          <= 1'b1;
            end else begin
              state <= ST_DATA;
            end
          end
        end
        ST_DATA: begin
          if (word_full) begin
            state          <= ST_WRITE;
            bus.byte_ready <= 1'b0;
            bus.mem_we     <= 1'b1;
            bus.mem_wdata  <= asm_word;
          end
        end
        ST_WRITE: begin
          bus.mem_addr <= bus.mem_addr + 32'd4;
          words_left   <= words_left - 1'b1;
          if (words_left == LEN_WIDTH'(1)) begin
            state    <= ST_DONE;
            done     <= 1'b1;
            cpu_hold <= 1'b0;
          end else begin
            state          <= ST_DATA;
            bus.byte_ready <= 1'b1;
          end
        end
        default: begin
          state          <= ST_IDLE;
          bus.byte_ready <= 1'b0;
        end
      endcase
    end
  end

endmodule
`default_nettype wire

// File: tb/tb_instruction_memory_loader.sv
`default_nettype none
// ============================================================================
// Module      : tb_instruction_memory_loader
// Description : Directed self-checking bench for instruction_memory_loader.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_instruction_memory_loader;

  logic clk = 1'b0;
  logic reset;
  logic start;
  logic cpu_hold;
  logic done;
  logic error;

  int compared   = 0;
  int mismatched = 0;

  logic [31:0] wr_addr[$];
  logic [31:0] wr_data[$];

  instruction_memory_loader_if bus ();

  instruction_memory_loader #(
    .MEMORY_SIZE  (1024),
    .BASE_ADDRESS (32'h0000_0000)
  ) dut (
    .clk      (clk),
    .reset    (reset),
    .start    (start),
    .bus      (bus),
    .cpu_hold (cpu_hold),
    .done     (done),
    .error    (error)
  );

  always #5 clk = ~clk;

  // Record every memory write strobe seen between clock edges.
  always @(negedge clk) begin
    if (bus.mem_we === 1'b1) begin
      wr_addr.push_back(bus.mem_addr);
      wr_data.push_back(bus.mem_wdata);
    end
  end

  initial begin
    #2_000_000;
    $display("FAIL watchdog observed=timeout expected=finish");
    $fatal(1, "watchdog expired");
  end

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    compared++;
    assert (obs === exp) else begin
      mismatched++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  task automatic pulse_start();
    start = 1'b1;
    @(negedge clk);
    start = 1'b0;
  endtask

  // Offer one byte after an optional idle gap; optionally pulse start in the gap.
  task automatic send_byte(input logic [7:0] b, input int gap, input bit start_in_gap);
    logic rdy;
    bit   ok;
    bus.byte_valid = 1'b0;
    for (int i = 0; i < gap; i++) begin
      start = start_in_gap && (i == 0);
      @(negedge clk);
    end
    start = 1'b0;
    bus.byte_in    = b;
    bus.byte_valid = 1'b1;
    ok = 1'b0;
    for (int t = 0; t < 50; t++) begin
      rdy = bus.byte_ready;
      @(negedge clk);
      if (rdy) begin
        ok = 1'b1;
        break;
      end
    end
    bus.byte_valid = 1'b0;
    check("byte_accepted", 32'(ok), 32'd1);
  endtask

  logic [7:0] img[10];

  initial begin
    img = '{8'h02, 8'h00, 8'h13, 8'h05, 8'h00, 8'h00, 8'h37, 8'h01, 8'h00, 8'h10};
    reset          = 1'b0;
    start          = 1'b0;
    bus.byte_in    = 8'h00;
    bus.byte_valid = 1'b0;
    repeat (3) @(negedge clk);

    // Reset values
    check("rst_ready", 32'(bus.byte_ready), 32'd0);
    check("rst_we",    32'(bus.mem_we),     32'd0);
    check("rst_addr",  bus.mem_addr,        32'h0);
    check("rst_wdata", bus.mem_wdata,       32'h0);
    check("rst_done",  32'(done),           32'd0);
    check("rst_error", 32'(error),          32'd0);
    check("rst_hold",  32'(cpu_hold),       32'd1);
    reset = 1'b1;

    // 1: bytes offered without start are not consumed
    bus.byte_in    = 8'hA5;
    bus.byte_valid = 1'b1;
    for (int i = 0; i < 4; i++) begin
      @(negedge clk);
      check("idle_ready", 32'(bus.byte_ready), 32'd0);
    end
    bus.byte_valid = 1'b0;
    check("idle_hold",   32'(cpu_hold),      32'd1);
    check("idle_no_we",  32'(wr_addr.size()), 32'd0);

    // 2: two-word image
    pulse_start();
    check("t2_ready_after_start", 32'(bus.byte_ready), 32'd1);
    for (int i = 0; i < 6; i++) send_byte(img[i], 0, 1'b0);
    check("t2_w0_we",    32'(bus.mem_we), 32'd1);
    check("t2_w0_addr",  bus.mem_addr,    32'h0);
    check("t2_w0_data",  bus.mem_wdata,   32'h0000_0513);
    check("t2_w0_ready", 32'(bus.byte_ready), 32'd0);
    for (int i = 6; i < 10; i++) send_byte(img[i], 0, 1'b0);
    check("t2_w1_we",    32'(bus.mem_we), 32'd1);
    check("t2_w1_addr",  bus.mem_addr,    32'h4);
    check("t2_w1_data",  bus.mem_wdata,   32'h1000_0137);
    check("t2_w1_done",  32'(done),       32'd0);
    @(negedge clk);
    check("t2_done",     32'(done),       32'd1);
    check("t2_hold",     32'(cpu_hold),   32'd0);
    check("t2_we_low",   32'(bus.mem_we), 32'd0);
    check("t2_next_addr", bus.mem_addr,   32'h8);
    check("t2_wdata_hold", bus.mem_wdata, 32'h1000_0137);
    check("t2_nwrites",  32'(wr_addr.size()), 32'd2);

    // 3: oversize image (N=257 > 256)
    pulse_start();
    check("t3_done_clr", 32'(done),     32'd0);
    check("t3_hold_set", 32'(cpu_hold), 32'd1);
    send_byte(8'h01, 0, 1'b0);
    send_byte(8'h01, 0, 1'b0);
    check("t3_error",    32'(error),          32'd1);
    check("t3_hold",     32'(cpu_hold),       32'd1);
    check("t3_ready",    32'(bus.byte_ready), 32'd0);
    repeat (2) @(negedge clk);
    check("t3_nwrites",  32'(wr_addr.size()), 32'd2);
    pulse_start();
    check("t3_error_clr", 32'(error),          32'd0);
    check("t3_ready_on",  32'(bus.byte_ready), 32'd1);

    // 4: empty image completes right after the length
    send_byte(8'h00, 0, 1'b0);
    send_byte(8'h00, 0, 1'b0);
    check("t4_done",     32'(done),           32'd1);
    check("t4_hold",     32'(cpu_hold),       32'd0);
    repeat (2) @(negedge clk);
    check("t4_nwrites",  32'(wr_addr.size()), 32'd2);

    // 5: same image with gaps and ignored start pulses mid-load
    wr_addr.delete();
    wr_data.delete();
    pulse_start();
    for (int i = 0; i < 10; i++) begin
      if ((i % 3 == 1) || (i == 6))
        send_byte(img[i], 2, 1'b1);
      else
        send_byte(img[i], int'($urandom_range(0, 3)), 1'b0);
    end
    check("t5_w1_we",   32'(bus.mem_we), 32'd1);
    check("t5_w1_addr", bus.mem_addr,    32'h4);
    @(negedge clk);
    check("t5_done",    32'(done),       32'd1);
    check("t5_nwrites", 32'(wr_addr.size()), 32'd2);
    if (wr_addr.size() == 2) begin
      check("t5_a0", wr_addr[0], 32'h0);
      check("t5_d0", wr_data[0], 32'h0000_0513);
      check("t5_a1", wr_addr[1], 32'h4);
      check("t5_d1", wr_data[1], 32'h1000_0137);
    end

    // 6: reset in the middle of a three-word load
    pulse_start();
    send_byte(8'h03, 0, 1'b0);
    send_byte(8'h00, 0, 1'b0);
    send_byte(8'h11, 0, 1'b0);
    send_byte(8'h22, 0, 1'b0);
    send_byte(8'h33, 0, 1'b0);
    send_byte(8'h44, 1, 1'b0);
    check("t6_w0_we",   32'(bus.mem_we), 32'd1);
    check("t6_w0_data", bus.mem_wdata,   32'h4433_2211);
    send_byte(8'h55, 0, 1'b0);
    reset = 1'b0;
    repeat (2) @(negedge clk);
    check("t6_rst_ready", 32'(bus.byte_ready), 32'd0);
    check("t6_rst_we",    32'(bus.mem_we),     32'd0);
    check("t6_rst_addr",  bus.mem_addr,        32'h0);
    check("t6_rst_wdata", bus.mem_wdata,       32'h0);
    check("t6_rst_done",  32'(done),           32'd0);
    check("t6_rst_error", 32'(error),          32'd0);
    check("t6_rst_hold",  32'(cpu_hold),       32'd1);
    reset = 1'b1;
    @(negedge clk);
    wr_addr.delete();
    wr_data.delete();
    pulse_start();
    send_byte(8'h01, 0, 1'b0);
    send_byte(8'h00, 0, 1'b0);
    send_byte(8'hAA, 0, 1'b0);
    send_byte(8'hBB, 0, 1'b0);
    send_byte(8'hCC, 0, 1'b0);
    send_byte(8'hDD, 0, 1'b0);
    check("t6_re_we",   32'(bus.mem_we), 32'd1);
    check("t6_re_addr", bus.mem_addr,    32'h0);
    check("t6_re_data", bus.mem_wdata,   32'hDDCC_BBAA);
    @(negedge clk);
    check("t6_re_done", 32'(done),       32'd1);
    check("t6_re_hold", 32'(cpu_hold),   32'd0);
    check("t6_nwrites", 32'(wr_addr.size()), 32'd1);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
    $finish;
  end

endmodule
`default_nettype wire
